// File: rtl/ieee_to_fixed_sequencer.sv
// IEEE-754 single to signed fixed-point converter.
// One shift per cycle, valid/ready on both sides.
module ieee_to_fixed_sequencer #(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_overflow,
  output logic             out_nan,
  output logic             out_inexact,
  output logic             busy
);

  localparam int MW = OUT_W + 24;
  localparam logic signed [9:0] FRAC_S = 10'(FRAC_W);
  localparam logic signed [9:0] SH_HI  = 10'(OUT_W - 25);
  localparam logic signed [9:0] SH_LO  = -10'sd24;
  localparam logic signed [9:0] BIAS   = 10'sd150;

  typedef enum logic [2:0] {
    IDLE, UNPACK, SHIFT, NEGATE, DONE
  } state_t;

  state_t          state;
  logic [31:0]     word;
  logic [MW-1:0]   mag;
  logic [9:0]      cnt;
  logic            dir_left;
  logic            sticky;

  logic [7:0]        e;
  logic [22:0]       man;
  logic signed [9:0] sh;
  logic [9:0]        sh_abs;
  logic [OUT_W-1:0]  mval;

  always_comb begin
    e      = word[30:23];
    man    = word[22:0];
    sh     = $signed({2'b00, e}) - BIAS + FRAC_S;
    sh_abs = sh[9] ? 10'(-sh) : 10'(sh);
    mval   = mag[OUT_W-1:0];
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Early exits pass through SHIFT with cnt=0 so every
  // path has the same fixed overhead of three cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word         <= '0;
      mag          <= '0;
      cnt          <= '0;
      dir_left     <= 1'b0;
      sticky       <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_nan      <= 1'b0;
      out_inexact  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            word         <= in_data;
            sticky       <= 1'b0;
            out_overflow <= 1'b0;
            out_nan      <= 1'b0;
            out_inexact  <= 1'b0;
            state        <= UNPACK;
          end
        end
        UNPACK: begin
          mag      <= MW'({1'b1, man});
          cnt      <= '0;
          dir_left <= ~sh[9];
          state    <= SHIFT;
          if (e == 8'hFF && man != '0) begin
            out_nan <= 1'b1;
            mag     <= '0;
          end else if (e == 8'hFF) begin
            out_overflow <= 1'b1;
          end else if (e == 8'h00) begin
            mag         <= '0;
            out_inexact <= (man != '0);
          end else if (sh > SH_HI) begin
            out_overflow <= 1'b1;
          end else if (sh < SH_LO) begin
            mag         <= '0;
            out_inexact <= 1'b1;
          end else begin
            cnt <= sh_abs;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 10'd1;
            if (dir_left) begin
              mag <= mag << 1;
            end else begin
              mag    <= mag >> 1;
              sticky <= sticky | mag[0];
            end
          end else begin
            state <= NEGATE;
          end
        end
        NEGATE: begin
          if (out_overflow)
            out_data <= word[31] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
          else if (out_nan)
            out_data <= '0;
          else
            out_data <= word[31] ? -mval : mval;
          out_inexact <= out_inexact | sticky;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
